multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_iter_muldiv.sv | 111 +++++++++++
 rtl/multicycle_alu.sv | 164 ++++++++++++++++
 tb/tb_multicycle_alu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcode map, FSM states,
// iterative-unit mode select and the default operand width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_INC  = 4'd2;
    localparam logic [3:0] OP_DEC  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_DIV  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_NAND = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd11;
    localparam logic [3:0] OP_XOR  = 4'd12;
    localparam logic [3:0] OP_XNOR = 4'd13;
    localparam logic [3:0] OP_NOT  = 4'd14;
    localparam logic [3:0] OP_BUF  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider. The first
// iteration is folded into the start edge so o_done pulses WIDTH cycles later.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  mode_t              i_mode,
    input  logic [WIDTH-1:0]   i_op1,
    input  logic [WIDTH-1:0]   i_op2,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_result
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    mode_t            r_mode;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_lo_init;
    logic [WIDTH-1:0] w_b_init;

    // {hi,lo} is the product/multiplier pair for MUL, remainder/quotient pair for DIV.
    function automatic logic [2*WIDTH-1:0] iter_step(
        input mode_t            mode,
        input logic [WIDTH-1:0] hi,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]     sum;
        logic [WIDTH:0]     remsh;
        logic [2*WIDTH-1:0] res;
        sum   = {(WIDTH+1){1'b0}};
        remsh = {(WIDTH+1){1'b0}};
        res   = {(2*WIDTH){1'b0}};
        case (mode)
            MODE_MUL: begin
                sum = lo[0] ? ({1'b0, hi} + {1'b0, b}) : {1'b0, hi};
                res = {sum[WIDTH:1], sum[0], lo[WIDTH-1:1]};
            end
            MODE_DIV: begin
                remsh = {hi, lo[WIDTH-1]};
                if (remsh >= {1'b0, b}) begin
                    remsh = remsh - {1'b0, b};
                    res   = {remsh[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
                end else begin
                    res   = {remsh[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
                end
            end
            default: res = {(2*WIDTH){1'b0}};
        endcase
        return res;
    endfunction

    // Route operands: MUL shifts the multiplier (op2), DIV shifts the dividend (op1).
    always_comb begin
        w_lo_init = i_op1;
        w_b_init  = i_op2;
        if (i_mode == MODE_MUL) begin
            w_lo_init = i_op2;
            w_b_init  = i_op1;
        end else begin
            w_lo_init = i_op1;
            w_b_init  = i_op2;
        end
    end

    // Iteration registers, counter and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= MODE_MUL;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= {CW{1'b0}};
            r_hi   <= {WIDTH{1'b0}};
            r_lo   <= {WIDTH{1'b0}};
            r_b    <= {WIDTH{1'b0}};
        end else if (i_start) begin
            r_mode       <= i_mode;
            r_b          <= w_b_init;
            {r_hi, r_lo} <= iter_step(i_mode, {WIDTH{1'b0}}, w_lo_init, w_b_init);
            r_cnt        <= ONE_CNT;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
        end else if (r_busy) begin
            {r_hi, r_lo} <= iter_step(r_mode, r_hi, r_lo, r_b);
            r_cnt        <= r_cnt + ONE_CNT;
            if (r_cnt == LAST_CNT) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else begin
                r_done <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_done   = r_done;
    assign o_result = {r_hi, r_lo};

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU top: command handshake FSM, single-cycle datapath and the
// result register; MUL/DIV are delegated to alu_iter_muldiv.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op1,
    input  logic [WIDTH-1:0]   op2,
    input  logic [3:0]         command,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               div_by_zero,
    output logic               busy
);

    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ZERO_W = {WIDTH{1'b0}};

    state_t             r_state;
    state_t             w_state_next;
    logic [2*WIDTH-1:0] r_out;
    logic               r_dbz;
    logic [2*WIDTH-1:0] w_single;
    logic [2*WIDTH-1:0] w_iter_result;
    logic               w_iter_done;
    logic               w_iter_start;
    mode_t              w_iter_mode;
    logic               w_op2_zero;
    logic               w_load_single;
    logic               w_load_iter;

    // DIV reaches here only with op2 == 0 and yields {op1, all ones}.
    function automatic logic [2*WIDTH-1:0] single_op(
        input logic [3:0]       cmd,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [2*WIDTH-1:0] ea;
        logic [2*WIDTH-1:0] eb;
        logic [2*WIDTH-1:0] res;
        ea  = {ZERO_W, a};
        eb  = {ZERO_W, b};
        res = {(2*WIDTH){1'b0}};
        case (cmd)
            OP_ADD:  res = ea + eb;
            OP_SUB:  res = ea - eb;
            OP_INC:  res = ea + ONE_2W;
            OP_DEC:  res = ea - ONE_2W;
            OP_DIV:  res = {a, {WIDTH{1'b1}}};
            OP_SHL:  res = {ea[2*WIDTH-2:0], 1'b0};
            OP_SHR:  res = {ZERO_W, 1'b0, a[WIDTH-1:1]};
            OP_AND:  res = {ZERO_W, a & b};
            OP_OR:   res = {ZERO_W, a | b};
            OP_NAND: res = {ZERO_W, ~(a & b)};
            OP_NOR:  res = {ZERO_W, ~(a | b)};
            OP_XOR:  res = {ZERO_W, a ^ b};
            OP_XNOR: res = {ZERO_W, ~(a ^ b)};
            OP_NOT:  res = {ZERO_W, ~a};
            OP_BUF:  res = {ZERO_W, a};
            default: res = {(2*WIDTH){1'b0}};
        endcase
        return res;
    endfunction

    assign w_op2_zero = (op2 == ZERO_W);
    assign w_single   = single_op(command, op1, op2);

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_iter_start),
        .i_mode   (w_iter_mode),
        .i_op1    (op1),
        .i_op2    (op2),
        .o_done   (w_iter_done),
        .o_result (w_iter_result)
    );

    // Next-state, iterative-unit start and result-load decode.
    always_comb begin
        w_state_next  = r_state;
        w_iter_start  = 1'b0;
        w_iter_mode   = MODE_MUL;
        w_load_single = 1'b0;
        w_load_iter   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (command == OP_MUL) begin
                        w_state_next = ST_MUL;
                        w_iter_start = 1'b1;
                        w_iter_mode  = MODE_MUL;
                    end else if ((command == OP_DIV) && !w_op2_zero) begin
                        w_state_next = ST_DIV;
                        w_iter_start = 1'b1;
                        w_iter_mode  = MODE_DIV;
                    end else begin
                        w_state_next  = ST_DONE;
                        w_load_single = 1'b1;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (w_iter_done) begin
                    w_state_next = ST_DONE;
                    w_load_iter  = 1'b1;
                end else begin
                    w_state_next = r_state;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Result and status register; holds through DONE until popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= {(2*WIDTH){1'b0}};
            r_dbz <= 1'b0;
        end else if (w_load_single) begin
            r_out <= w_single;
            r_dbz <= (command == OP_DIV) && w_op2_zero;
        end else if (w_load_iter) begin
            r_out <= w_iter_result;
            r_dbz <= 1'b0;
        end else begin
            r_out <= r_out;
            r_dbz <= r_dbz;
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign out         = r_out;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed scenarios plus randomized
// traffic scored against an arithmetic reference model (WIDTH=8 and WIDTH=16).
module tb_multicycle_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready, div_by_zero, busy;
    logic [7:0]  op1, op2;
    logic [3:0]  command;
    logic [15:0] out;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_dbz, h_busy;
    logic [15:0] h_op1, h_op2;
    logic [3:0]  h_command;
    logic [31:0] h_out;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_alu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .command(command), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .div_by_zero(div_by_zero), .busy(busy)
    );

    multicycle_alu #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .op1(h_op1), .op2(h_op2), .command(h_command), .out_valid(h_out_valid),
        .out_ready(h_out_ready), .out(h_out), .div_by_zero(h_dbz), .busy(h_busy)
    );

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned model(input int w, input logic [3:0] cmd,
                                              input longint unsigned a, input longint unsigned b);
        longint unsigned m1 = (64'd1 << w) - 64'd1;
        longint unsigned m2 = (64'd1 << (2 * w)) - 64'd1;
        case (cmd)
            OP_ADD:  return a + b;
            OP_SUB:  return (a - b) & m2;
            OP_INC:  return a + 64'd1;
            OP_DEC:  return (a - 64'd1) & m2;
            OP_MUL:  return a * b;
            OP_DIV:  return (b == 64'd0) ? ((a << w) | m1) : (((a % b) << w) | (a / b));
            OP_SHL:  return a << 1;
            OP_SHR:  return a >> 1;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_NAND: return ~(a & b) & m1;
            OP_NOR:  return ~(a | b) & m1;
            OP_XOR:  return a ^ b;
            OP_XNOR: return ~(a ^ b) & m1;
            OP_NOT:  return ~a & m1;
            default: return a;
        endcase
    endfunction

    function automatic int exp_latency(input int w, input logic [3:0] cmd, input longint unsigned b);
        return (cmd == OP_MUL || (cmd == OP_DIV && b != 64'd0)) ? (w + 1) : 1;
    endfunction

    // One WIDTH=8 transaction; hold > 0 stalls the consumer and pokes in_valid meanwhile.
    task automatic do_op8(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b, input int hold);
        longint unsigned exp = model(8, cmd, a, b);
        int exp_lat = exp_latency(8, cmd, b);
        int lat;
        logic [15:0] held;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; command = cmd; op1 = a; op2 = b;
        @(negedge clk);
        in_valid = 1'b0; op1 = 8'($urandom); op2 = 8'($urandom); command = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            check("busy_during_iter", {busy, in_ready}, 2'b10);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("result", out, exp);
        check("div_by_zero", div_by_zero, (cmd == OP_DIV && b == 8'd0));
        held = out;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; command = OP_ADD; op1 = 8'($urandom); op2 = 8'($urandom);
            @(negedge clk);
            check("hold_stable", {out_valid, in_ready, out}, {2'b10, held});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("popped", {out_valid, in_ready}, 2'b01);
    endtask

    task automatic do_op16(input logic [3:0] cmd, input logic [15:0] a, input logic [15:0] b);
        longint unsigned exp = model(16, cmd, a, b);
        int exp_lat = exp_latency(16, cmd, b);
        int lat;
        @(negedge clk);
        h_in_valid = 1'b1; h_command = cmd; h_op1 = a; h_op2 = b;
        @(negedge clk);
        h_in_valid = 1'b0;
        lat = 1;
        while (!h_out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("w16_latency", lat, exp_lat);
        check("w16_result", h_out, exp);
        check("w16_div_by_zero", h_dbz, (cmd == OP_DIV && b == 16'd0));
        h_out_ready = 1'b1;
        @(negedge clk);
        h_out_ready = 1'b0;
    endtask

    // Randomized WIDTH=8 traffic: at most one command outstanding, so in_ready == queue empty.
    task automatic run8(input int ncyc, input int single_only, input int pv, input int pr, output int nres);
        longint unsigned q[$];
        logic            dq[$];
        logic [3:0]      cmd;
        logic [7:0]      a, b;
        logic            was_empty;
        nres = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            was_empty = (q.size() == 0);
            check("rand_in_ready", in_ready, was_empty);
            if (out_valid) begin
                if (was_empty) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    check("rand_result", out, q[0]);
                    check("rand_dbz", div_by_zero, dq[0]);
                end
            end
            out_ready = ($urandom_range(0, 99) < pr);
            if (out_valid && out_ready && !was_empty) begin
                void'(q.pop_front());
                void'(dq.pop_front());
                nres++;
            end
            cmd = 4'($urandom_range(0, 13));
            if (single_only != 0 && cmd >= 4'd4) cmd = cmd + 4'd2;
            if (single_only == 0) cmd = 4'($urandom_range(0, 15));
            a = 8'($urandom);
            b = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            in_valid = ($urandom_range(0, 99) < pv);
            command = cmd; op1 = a; op2 = b;
            if (in_valid && was_empty) begin
                q.push_back(model(8, cmd, a, b));
                dq.push_back(cmd == OP_DIV && b == 8'd0);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 40 && q.size() > 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                check("drain_result", out, q[0]);
                void'(q.pop_front());
                void'(dq.pop_front());
                nres++;
            end
        end
        check("drain_empty", q.size(), 0);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic seen_valid;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op1 = 8'd0; op2 = 8'd0; command = 4'd0;
        h_in_valid = 1'b0; h_out_ready = 1'b0; h_op1 = 16'd0; h_op2 = 16'd0; h_command = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_state", {out_valid, in_ready, busy, div_by_zero, out}, {4'b0100, 16'h0000});
        rst = 1'b0;

        do_op8(OP_ADD, 8'd200, 8'd100, 0);
        check("add_const", out, 16'h012C);
        do_op8(OP_MUL, 8'd255, 8'd255, 0);
        check("mul_const", out, 16'hFE01);
        do_op8(OP_DIV, 8'd200, 8'd7, 0);
        check("div_const", out, 16'h041C);
        do_op8(OP_DIV, 8'd5, 8'd0, 0);
        check("div0_const", {div_by_zero, out}, {1'b1, 16'h05FF});
        do_op8(OP_SUB, 8'd3, 8'd5, 5);
        check("sub_const", out, 16'hFFFE);
        do_op8(OP_INC, 8'd255, 8'd0, 0);
        do_op8(OP_DEC, 8'd0, 8'd0, 0);
        do_op8(OP_SHL, 8'h81, 8'd0, 0);
        do_op8(OP_SHR, 8'h81, 8'd0, 0);
        do_op8(OP_MUL, 8'd0, 8'd77, 0);
        do_op8(OP_DIV, 8'd3, 8'd200, 0);

        // Reset on the 4th edge after a MUL accept must abort it without a result.
        @(negedge clk);
        in_valid = 1'b1; command = OP_MUL; op1 = 8'd13; op2 = 8'd11;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", {out_valid, in_ready, busy, out}, {3'b010, 16'h0000});
        seen_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen_valid = seen_valid | out_valid;
        end
        check("abort_no_result", seen_valid, 0);
        do_op8(OP_ADD, 8'd1, 8'd1, 0);
        check("add_after_abort", out, 16'h0002);

        // A command presented together with reset is dropped.
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; command = OP_ADD; op1 = 8'd5; op2 = 8'd6;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("rst_valid_edge", {out_valid, in_ready}, 2'b01);
        @(negedge clk);
        check("rst_valid_after", out_valid, 0);

        run8(20, 1, 100, 100, n);
        check("throughput", n, 10);
        run8(400, 0, 60, 60, n);

        do_op16(OP_SHL, 16'h8001, 16'h0000);
        check("w16_shl_const", h_out, 32'h00010002);
        do_op16(OP_NOT, 16'h00FF, 16'h0000);
        check("w16_not_const", h_out, 32'h0000FF00);
        do_op16(OP_DIV, 16'd1234, 16'd0);
        for (int i = 0; i < 6; i++) begin
            do_op16(OP_MUL, 16'($urandom), 16'($urandom));
            do_op16(OP_DIV, 16'($urandom), 16'($urandom_range(1, 65535)));
            do_op16(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
